// File: rtl/cartoon_pkg.sv
// Shared types and default widths for the pixel scan controller.
`timescale 1ns/1ps
package cartoon_pkg;

  localparam int DIM_W_DEFAULT  = 10;
  localparam int ADDR_W_DEFAULT = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    REQ  = 2'd2,
    DONE = 2'd3
  } scan_state_t;

endpackage

// File: rtl/pixel_scan_addr_gen.sv
// Column/row/address counters for the raster scan, driven by load/advance strobes.
`timescale 1ns/1ps
module pixel_scan_addr_gen
  import cartoon_pkg::*;
#(
  parameter int DIM_W  = DIM_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [DIM_W-1:0]  width_m1_i,
  input  logic [DIM_W-1:0]  height_m1_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] pitch_i,
  output logic [DIM_W-1:0]  col_o,
  output logic [DIM_W-1:0]  row_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_col_o,
  output logic              last_row_o
);

  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] row_start_q, row_start_d;

  assign last_col_o = (col_q == width_m1_i);
  assign last_row_o = (row_q == height_m1_i);

  // Address sums wrap naturally modulo 2^ADDR_W.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    addr_d      = addr_q;
    row_start_d = row_start_q;
    if (load_i) begin
      col_d       = '0;
      row_d       = '0;
      addr_d      = base_i;
      row_start_d = base_i;
    end else if (adv_i) begin
      if (last_col_o) begin
        col_d       = '0;
        row_d       = row_q + DIM_W'(1);
        addr_d      = row_start_q + pitch_i;
        row_start_d = row_start_q + pitch_i;
      end else begin
        col_d  = col_q + DIM_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      row_start_q <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      addr_q      <= addr_d;
      row_start_q <= row_start_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/pixel_scan_ctrl.sv
// Raster-scan read request FSM. Define PIXEL_SCAN_ABORT_EN to add the abort input.
`timescale 1ns/1ps
module pixel_scan_ctrl
  import cartoon_pkg::*;
#(
  parameter int DIM_W  = DIM_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] row_pitch,
  input  logic              mem_ready,
`ifdef PIXEL_SCAN_ABORT_EN
  input  logic              abort,
`endif
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DIM_W-1:0]  col,
  output logic [DIM_W-1:0]  row,
  output logic              busy,
  output logic              done
);

  scan_state_t       state_q, state_d;
  logic [DIM_W-1:0]  width_m1_q, width_m1_d;
  logic [DIM_W-1:0]  height_m1_q, height_m1_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] pitch_q, pitch_d;
  logic              last_col, last_row, hs, final_px, accept;

  assign accept   = start && (img_width != '0) && (img_height != '0);
  assign hs       = (state_q == REQ) && mem_ready;
  assign final_px = last_col && last_row;

  always_comb begin
    state_d     = state_q;
    width_m1_d  = width_m1_q;
    height_m1_d = height_m1_q;
    base_d      = base_q;
    pitch_d     = pitch_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = accept ? LOAD : DONE;
        if (accept) begin
          width_m1_d  = img_width - DIM_W'(1);
          height_m1_d = img_height - DIM_W'(1);
          base_d      = base_addr;
          pitch_d     = row_pitch;
        end
      end
      LOAD:    state_d = REQ;
      REQ:     if (hs && final_px) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef PIXEL_SCAN_ABORT_EN
    // Abort wins over a same-cycle handshake; that transfer still counts.
    if (abort && (state_q == LOAD || state_q == REQ)) state_d = IDLE;
`endif
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      width_m1_q  <= '0;
      height_m1_q <= '0;
      base_q      <= '0;
      pitch_q     <= '0;
    end else begin
      state_q     <= state_d;
      width_m1_q  <= width_m1_d;
      height_m1_q <= height_m1_d;
      base_q      <= base_d;
      pitch_q     <= pitch_d;
    end
  end

  pixel_scan_addr_gen #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .n_rst       (n_rst),
    .load_i      (state_q == LOAD),
    .adv_i       (hs && !final_px),
    .width_m1_i  (width_m1_q),
    .height_m1_i (height_m1_q),
    .base_i      (base_q),
    .pitch_i     (pitch_q),
    .col_o       (col),
    .row_o       (row),
    .addr_o      (mem_addr),
    .last_col_o  (last_col),
    .last_row_o  (last_row)
  );

  assign mem_req = (state_q == REQ);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Directed bench for pixel_scan_ctrl with immediate-assertion checks.
`timescale 1ns/1ps
module tb_pixel_scan_ctrl;

  localparam int DIM_W  = 10;
  localparam int ADDR_W = 18;

  logic              clk = 1'b0;
  logic              n_rst = 1'b1;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  img_width = '0;
  logic [DIM_W-1:0]  img_height = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] row_pitch = '0;
  logic              mem_ready = 1'b0;
`ifdef PIXEL_SCAN_ABORT_EN
  logic              abort = 1'b0;
`endif
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DIM_W-1:0]  col;
  logic [DIM_W-1:0]  row;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;

  pixel_scan_ctrl #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .img_width  (img_width),
    .img_height (img_height),
    .base_addr  (base_addr),
    .row_pitch  (row_pitch),
    .mem_ready  (mem_ready),
`ifdef PIXEL_SCAN_ABORT_EN
    .abort      (abort),
`endif
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .col        (col),
    .row        (row),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"},  32'(mem_req),  32'h0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_col"},  32'(col),      32'h0);
    chk({tag, "_row"},  32'(row),      32'h0);
    chk({tag, "_busy"}, 32'(busy),     32'h0);
    chk({tag, "_done"}, 32'(done),     32'h0);
  endtask

  // Full scan with mem_ready held high; expected address = base + r*pitch + c (mod 2^18).
  task automatic scan_check(input string tag, input int w, input int h,
                            input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] pitch);
    logic [ADDR_W-1:0] ea;
    img_width  = DIM_W'(w);
    img_height = DIM_W'(h);
    base_addr  = base;
    row_pitch  = pitch;
    mem_ready  = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_load_req"},  32'(mem_req), 32'h0);
    chk({tag, "_load_busy"}, 32'(busy),    32'h1);
    tick();
    for (int i = 0; i < w * h; i++) begin
      ea = base + ADDR_W'(i / w) * pitch + ADDR_W'(i % w);
      chk({tag, "_req"},  32'(mem_req),  32'h1);
      chk({tag, "_addr"}, 32'(mem_addr), 32'(ea));
      chk({tag, "_col"},  32'(col),      32'(i % w));
      chk({tag, "_row"},  32'(row),      32'(i / w));
      tick();
    end
    chk({tag, "_done"},     32'(done),    32'h1);
    chk({tag, "_done_req"}, 32'(mem_req), 32'h0);
    tick();
    chk({tag, "_done_clr"}, 32'(done), 32'h0);
    chk({tag, "_idle"},     32'(busy), 32'h0);
  endtask

  initial begin
    int hs;
    int dn;

    // Reset state
    #2 n_rst = 1'b0;
    tick();
    tick();
    chk_idle_outputs("reset");
    n_rst = 1'b1;
    tick();

    // 4x2 image, back-to-back
    scan_check("img4x2", 4, 2, 18'h100, 18'h10);

    // 3x1 image with mem_ready toggling
    img_width = 3; img_height = 1; base_addr = 18'h200; row_pitch = 18'h40;
    mem_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    hs = 0;
    dn = 0;
    for (int i = 0; i < 16; i++) begin
      mem_ready = i[0];
      if (mem_req) chk("tog_addr", 32'(mem_addr), 32'h200 + 32'(hs));
      if (mem_req && mem_ready) hs++;
      if (done) dn++;
      tick();
    end
    chk("tog_handshakes", 32'(hs), 32'd3);
    chk("tog_done_pulses", 32'(dn), 32'd1);
    mem_ready = 1'b1;

    // Zero width: immediate done, no request
    img_width = 0; img_height = 5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zw_done", 32'(done),    32'h1);
    chk("zw_busy", 32'(busy),    32'h1);
    chk("zw_req",  32'(mem_req), 32'h0);
    tick();
    chk("zw_done_clr", 32'(done), 32'h0);
    chk("zw_idle",     32'(busy), 32'h0);
    chk("zw_req2",     32'(mem_req), 32'h0);

    // Restart ignored mid-frame, then asynchronous reset mid-frame
    img_width = 4; img_height = 2; base_addr = 18'h000; row_pitch = 18'h10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_a0", 32'(mem_addr), 32'h0);
    tick();
    chk("mid_a1", 32'(mem_addr), 32'h1);
    base_addr = 18'h300; img_width = 1; img_height = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_a2", 32'(mem_addr), 32'h2);
    tick();
    chk("mid_a3", 32'(mem_addr), 32'h3);
    chk("mid_req", 32'(mem_req), 32'h1);
    n_rst = 1'b0;
    #1;
    chk_idle_outputs("mid_rst");
    tick();
    tick();
    n_rst = 1'b1;
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) dn++;
      tick();
    end
    chk("post_rst_quiet", 32'(dn), 32'd0);
    scan_check("fresh2x2", 2, 2, 18'h40, 18'h20);

    // Address wrap past the top of the space
    scan_check("wrap4x1", 4, 1, 18'h3FFFE, 18'h8);

`ifdef PIXEL_SCAN_ABORT_EN
    // Abort coincident with the second handshake
    img_width = 4; img_height = 2; base_addr = 18'h500; row_pitch = 18'h10;
    mem_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("ab_a0", 32'(mem_addr), 32'h500);
    tick();
    chk("ab_a1", 32'(mem_addr), 32'h501);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_req",  32'(mem_req), 32'h0);
    chk("ab_busy", 32'(busy),    32'h0);
    chk("ab_done", 32'(done),    32'h0);
    tick();
    chk("ab_done2", 32'(done), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
